// File: rtl/clock_time_counter_if.sv
// ---------------------------------------------------------------------------
// clock_time_counter_if
//   Groups the control and time signals of the clock_time_counter core.
//   master : the controller side (drives run/load/step, observes time)
//   slave  : the timekeeping core
//
//   en                  run (1) / stop (0), level
//   set_req             load request, acted on at its rising edge
//   set_hr/min/sec      load value, binary
//   inc_min/inc_hr      single-cycle manual step pulses (stopped only)
//   hr/min/sec          current time, binary
//   set_ack/set_err     one-cycle load accept / reject pulses
//   sec_pulse           one-cycle pulse on every tick-driven seconds advance
//   day_wrap            one-cycle pulse on 23:59:59 -> 00:00:00
// ---------------------------------------------------------------------------
interface clock_time_counter_if;
    logic       en;
    logic       set_req;
    logic [4:0] set_hr;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       inc_min;
    logic       inc_hr;
    logic [4:0] hr;
    logic [5:0] min;
    logic [5:0] sec;
    logic       set_ack;
    logic       set_err;
    logic       sec_pulse;
    logic       day_wrap;

    modport master (
        output en, set_req, set_hr, set_min, set_sec, inc_min, inc_hr,
        input  hr, min, sec, set_ack, set_err, sec_pulse, day_wrap
    );

    modport slave (
        input  en, set_req, set_hr, set_min, set_sec, inc_min, inc_hr,
        output hr, min, sec, set_ack, set_err, sec_pulse, day_wrap
    );
endinterface

// File: rtl/clock_time_counter.sv
// ---------------------------------------------------------------------------
// clock_time_counter
//   24-hour hh:mm:ss timekeeping core. A prescaler divides clk by DIV to make
//   a 1 Hz tick while running; time can be loaded through a req/ack
//   handshake with range checking and stepped manually while stopped.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-low reset
//     bus    clock_time_counter_if.slave (run/load/step in, time/pulses out)
//
//   Parameter:
//     DIV    clk cycles per second (>= 2)
// ---------------------------------------------------------------------------
module clock_time_counter #(
    parameter int DIV = 100000000
) (
    input  logic                  clk,
    input  logic                  reset,
    clock_time_counter_if.slave   bus
);

    localparam int                CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]  PRESC_MAX = CNT_W'(DIV - 1);

    localparam logic [0:0] ST_STOPPED = 1'b0;
    localparam logic [0:0] ST_RUNNING = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_presc;
    logic [4:0]       r_hr;
    logic [5:0]       r_min;
    logic [5:0]       r_sec;
    logic             r_req_d;
    logic             r_set_ack;
    logic             r_set_err;
    logic             r_sec_pulse;
    logic             r_day_wrap;

    logic [0:0]       w_next_state;
    logic             w_tick;
    logic             w_set_rise;
    logic             w_set_ok;
    logic             w_load;
    logic             w_reject;
    logic             w_step_ok;
    logic             w_midnight;
    logic [CNT_W-1:0] w_presc_nxt;
    logic [4:0]       w_hr_nxt;
    logic [5:0]       w_min_nxt;
    logic [5:0]       w_sec_nxt;

    assign w_next_state = bus.en ? ST_RUNNING : ST_STOPPED;
    assign w_tick       = (r_state == ST_RUNNING) && (r_presc == PRESC_MAX);
    assign w_set_rise   = bus.set_req && !r_req_d;
    assign w_set_ok     = (bus.set_hr < 5'd24) && (bus.set_min < 6'd60) &&
                          (bus.set_sec < 6'd60);
    assign w_load       = w_set_rise && w_set_ok;
    assign w_reject     = w_set_rise && !w_set_ok;
    // Manual steps are judged against the state being entered, so a step
    // arriving with en rising is dropped.
    assign w_step_ok    = (r_state == ST_STOPPED) && (w_next_state == ST_STOPPED);
    assign w_midnight   = (r_hr == 5'd23) && (r_min == 6'd59) && (r_sec == 6'd59);

    // Prescaler: held at zero while stopped, cleared when leaving RUNNING and
    // on an accepted load so the next second is always a full DIV cycles.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // infer a latch.
        w_presc_nxt = '0;
        if ((r_state == ST_RUNNING) && (w_next_state == ST_RUNNING) && !w_load) begin
            w_presc_nxt = w_tick ? '0 : r_presc + CNT_W'(1);
        end
    end

    // Time update: load beats tick beats manual step.
    always_comb begin
        w_hr_nxt  = r_hr;
        w_min_nxt = r_min;
        w_sec_nxt = r_sec;
        if (w_load) begin
            w_hr_nxt  = bus.set_hr;
            w_min_nxt = bus.set_min;
            w_sec_nxt = bus.set_sec;
        end else if (w_tick) begin
            if (r_sec == 6'd59) begin
                w_sec_nxt = '0;
                if (r_min == 6'd59) begin
                    w_min_nxt = '0;
                    w_hr_nxt  = (r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1;
                end else begin
                    w_min_nxt = r_min + 6'd1;
                end
            end else begin
                w_sec_nxt = r_sec + 6'd1;
            end
        end else if (w_step_ok) begin
            if (bus.inc_min) begin
                w_min_nxt = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
            end
            if (bus.inc_hr) begin
                w_hr_nxt = (r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_STOPPED;
            r_presc     <= '0;
            r_hr        <= '0;
            r_min       <= '0;
            r_sec       <= '0;
            // Seeded high so a request held through reset release is not
            // mistaken for a fresh rising edge.
            r_req_d     <= 1'b1;
            r_set_ack   <= 1'b0;
            r_set_err   <= 1'b0;
            r_sec_pulse <= 1'b0;
            r_day_wrap  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values.
            r_state     <= w_next_state;
            r_presc     <= w_presc_nxt;
            r_hr        <= w_hr_nxt;
            r_min       <= w_min_nxt;
            r_sec       <= w_sec_nxt;
            r_req_d     <= bus.set_req;
            r_set_ack   <= w_load;
            r_set_err   <= w_reject;
            r_sec_pulse <= w_tick && !w_load;
            r_day_wrap  <= w_tick && !w_load && w_midnight;
        end
    end

    assign bus.hr        = r_hr;
    assign bus.min       = r_min;
    assign bus.sec       = r_sec;
    assign bus.set_ack   = r_set_ack;
    assign bus.set_err   = r_set_err;
    assign bus.sec_pulse = r_sec_pulse;
    assign bus.day_wrap  = r_day_wrap;

endmodule
